serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor: computes a - b - bin one bit per clock, LSB first.
- Built around a single full-subtractor cell plus a registered borrow; the sequential counterpart of the team's 1-bit full adder.
- Used where area matters more than latency.
- start/busy/done handshake; the result is held stable between operations.

---
 rtl/serial_subtractor.sv | 158 +++++++++++++++
 tb/tb_serial_subtractor.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
// ------------------------------------------------------------------------
// Bit-serial subtractor: computes (a - b - bin) mod 2^WIDTH one bit per
// clock, LSB first. It uses one full-subtractor cell with a registered
// borrow, so it trades latency for area. Each operation takes WIDTH cycles
// from acceptance to done.
//
// Parameters:
//   WIDTH  operand/result width in bits (2..32)
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request, sampled only while idle
//   a      in   minuend, captured when start is accepted
//   b      in   subtrahend, captured when start is accepted
//   bin    in   borrow-in, captured when start is accepted
//   busy   out  high while an operation is in progress
//   done   out  one-cycle pulse when diff/bout update
//   diff   out  result, held stable until the next done
//   ovf    out  signed overflow flag (only with SERIAL_SUB_OVF_EN)
//   bout   out  final borrow-out (1 = unsigned a < b + bin)
//
// Optional feature:
//   Define SERIAL_SUB_OVF_EN to add the ovf output. It reports signed
//   two's-complement overflow of a - b - bin.
// ------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Holds only the WIDTH-1 bits already produced. The bit from the
    // current cycle is always taken from the cell output, so the final
    // result is {cell bit, r_sr}.
    logic [WIDTH-2:0] r_sr;
    logic [WIDTH-1:0] r_full;
    logic             brw;
    logic [CW-1:0]    cnt;

    logic             d;
    logic             brw_next;
    logic             last;

`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    // Full-subtractor cell acting on the current LSBs.
    assign d        = a_sr[0] ^ b_sr[0] ^ brw;
    assign brw_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);
    assign r_full   = {d, r_sr};
    assign last     = (state == RUN) && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath. Operands are captured only on acceptance, so a start that
    // arrives while RUN cannot disturb an operation in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
            done  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    a_sr  <= a;
                    b_sr  <= b;
                    brw   <= bin;
                    cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb <= a[WIDTH-1];
                    b_msb <= b[WIDTH-1];
`endif
                end
            end else begin
                a_sr <= a_sr >> 1;
                b_sr <= b_sr >> 1;
                r_sr <= r_full[WIDTH-1:1];
                brw  <= brw_next;
                cnt  <= cnt + 1'b1;
                if (last) begin
                    diff <= r_full;
                    bout <= brw_next;
                    done <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                    ovf  <= (a_msb != b_msb) && (r_full[WIDTH-1] != a_msb);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
// ------------------------------------------------------------------------
// Self-checking bench for serial_subtractor with WIDTH=8. The expected
// results come from plain integer arithmetic on the operands.
// ------------------------------------------------------------------------
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
`endif

    int vectors;
    int errors;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
`ifdef SERIAL_SUB_OVF_EN
        .ovf   (ovf),
`endif
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic.
    function automatic logic [8:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                         input logic mbin);
        int t;
        logic [7:0] dd;
        t  = int'(ma) - int'(mb) - int'(mbin);
        dd = t[7:0];
        return {(t < 0), dd};
    endfunction

    function automatic logic model_ovf(input logic [7:0] ma, input logic [7:0] mb,
                                       input logic mbin);
        int t;
        t = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        return (t > 127) || (t < -128);
    endfunction

    // Runs one operation end to end. It checks latency, busy, diff
    // stability while busy, the result, and that done is a single pulse.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                          input string name);
        logic [8:0] exp;
        logic [7:0] held;
        int cyc;
        int busy_cnt;
        bit moved;
        exp = model(ta, tb, tbin);
        @(negedge clk);
        start = 1'b1; a = ta; b = tb; bin = tbin;
        held = diff;
        @(negedge clk);
        start = 1'b0; a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        cyc = 0; busy_cnt = 0; moved = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) busy_cnt++;
            if (diff !== held) moved = 1;
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (cyc !== 8) begin
            errors++;
            $display("[TB] FAIL %s latency: got %0d cycles, expected 8", name, cyc);
        end
        vectors++;
        if (busy_cnt !== 8 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s busy: high %0d cycles, busy at done=%b, expected 8 and 0",
                     name, busy_cnt, busy);
        end
        vectors++;
        if (moved) begin
            errors++;
            $display("[TB] FAIL %s diff_stable: diff changed before done, expected held %h", name, held);
        end
        vectors++;
        if (diff !== exp[7:0] || bout !== exp[8]) begin
            errors++;
            $display("[TB] FAIL %s result: diff=%h bout=%b, expected diff=%h bout=%b",
                     name, diff, bout, exp[7:0], exp[8]);
        end
`ifdef SERIAL_SUB_OVF_EN
        vectors++;
        if (ovf !== model_ovf(ta, tb, tbin)) begin
            errors++;
            $display("[TB] FAIL %s ovf: got %b, expected %b", name, ovf, model_ovf(ta, tb, tbin));
        end
`endif
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || diff !== exp[7:0]) begin
            errors++;
            $display("[TB] FAIL %s done_pulse: done=%b diff=%h, expected done=0 diff=%h",
                     name, done, diff, exp[7:0]);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset: busy=%b done=%b diff=%h bout=%b, expected all 0",
                     busy, done, diff, bout);
        end
`ifdef SERIAL_SUB_OVF_EN
        vectors++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ovf: got %b, expected 0", ovf);
        end
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_op(8'h05, 8'h03, 1'b0, "basic");
    endtask

    task automatic test_borrow();
        logic [7:0] ta [3] = '{8'h03, 8'h00, 8'hFF};
        logic [7:0] tb [3] = '{8'h05, 8'h00, 8'hFF};
        logic       tc [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], tc[i], "borrow");
        end
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf();
        run_op(8'h80, 8'h01, 1'b0, "ovf_neg");
        run_op(8'h7F, 8'hFF, 1'b0, "ovf_pos");
        run_op(8'h05, 8'h03, 1'b0, "ovf_none");
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom), "random");
        end
    endtask

    // A second start at cycle 3 of an operation must be ignored.
    task automatic test_start_while_busy();
        int cyc;
        @(negedge clk);
        start = 1'b1; a = 8'h10; b = 8'h01; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (cyc == 2) begin
                start = 1'b1; a = 8'hAA; b = 8'h55; bin = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        vectors++;
        if (cyc !== 8 || diff !== 8'h0F || bout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ignore_start: cycles=%0d diff=%h bout=%b, expected 8 0f 0",
                     cyc, diff, bout);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ignore_idle: busy=%b done=%b, expected idle", busy, done);
        end
    endtask

    // A start raised during the done cycle is accepted at the next edge.
    task automatic test_back_to_back();
        logic [8:0] first;
        int cyc;
        bit moved;
        first = model(8'h37, 8'h12, 1'b1);
        run_op(8'h37, 8'h12, 1'b1, "b2b_first");
        @(negedge clk);
        start = 1'b1; a = 8'h50; b = 8'h20; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (done !== 1'b1) @(negedge clk);
        start = 1'b1; a = 8'h20; b = 8'h10; bin = 1'b0;
        @(negedge clk);
        start = 1'b0; a = 8'hEE; b = 8'h77;
        first = model(8'h50, 8'h20, 1'b0);
        cyc = 0; moved = 0;
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_accept: busy=%b done=%b, expected 1 0", busy, done);
        end
        while (done !== 1'b1 && cyc < 40) begin
            if (diff !== first[7:0]) moved = 1;
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (moved) begin
            errors++;
            $display("[TB] FAIL b2b_hold: diff changed between dones, expected %h", first[7:0]);
        end
        vectors++;
        if (cyc !== 8 || diff !== 8'h10 || bout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_second: cycles=%0d diff=%h bout=%b, expected 8 10 0",
                     cyc, diff, bout);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        bit seen;
        @(negedge clk);
        start = 1'b1; a = 8'h80; b = 8'h01; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid: busy=%b done=%b diff=%h bout=%b, expected all 0",
                     busy, done, diff, bout);
        end
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
            if (busy !== 1'b0) seen = 1;
            if (cyc_release_now()) rst_n = 1'b1;
        end
        vectors++;
        if (seen) begin
            errors++;
            $display("[TB] FAIL reset_mid_nodone: saw done or busy after abort, expected neither");
        end
        run_op(8'h09, 8'h04, 1'b0, "after_reset");
    endtask

    // Releases reset a few cycles after the mid-operation abort.
    int release_cnt = 0;
    function automatic bit cyc_release_now();
        release_cnt++;
        return release_cnt == 3;
    endfunction

    initial begin
        vectors = 0;
        errors  = 0;
        rst_n   = 1'b1;
        start   = 1'b0;
        a       = 8'h00;
        b       = 8'h00;
        bin     = 1'b0;
        test_reset();
        test_basic();
        test_borrow();
`ifdef SERIAL_SUB_OVF_EN
        test_ovf();
`endif
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
